// File: rtl/fifo_pkg.sv
// Shared pointer helpers for the async FIFO: Gray/binary conversion and depth.
package fifo_pkg;

    localparam int unsigned FIFO_PTR_MAX = 32;

    function automatic int unsigned fifo_depth(input int unsigned addrsize);
        return 32'd1 << addrsize;
    endfunction

    function automatic logic [FIFO_PTR_MAX-1:0] bin2gray(input logic [FIFO_PTR_MAX-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Callers zero-extend narrower pointers in and size-cast the result back down.
    function automatic logic [FIFO_PTR_MAX-1:0] gray2bin(input logic [FIFO_PTR_MAX-1:0] g);
        logic [FIFO_PTR_MAX-1:0] b;
        b = '0;
        b[FIFO_PTR_MAX-1] = g[FIFO_PTR_MAX-1];
        for (int unsigned i = FIFO_PTR_MAX - 1; i > 0; i--) begin
            b[i-1] = b[i] ^ g[i-1];
        end
        return b;
    endfunction

endpackage

// File: rtl/sync_w2r.sv
// Two-flop synchronizer bringing the Gray write pointer into the rclk domain.
module sync_w2r #(
    parameter int ADDRSIZE = 4
) (
    input  logic                rclk,
    input  logic                rrst,
    input  logic [ADDRSIZE:0]   wptr,
    output logic [ADDRSIZE:0]   rq2_wptr
);

    logic [ADDRSIZE:0] rq1_wptr;

    always_ff @(posedge rclk) begin
        if (rrst) begin
            rq1_wptr <= '0;
            rq2_wptr <= '0;
        end else begin
            rq1_wptr <= wptr;
            rq2_wptr <= rq1_wptr;
        end
    end

endmodule

// File: rtl/fifo_rd_ctrl.sv
// Async FIFO read-side controller: Gray read pointer, registered empty, one-entry output register.
// Optional macro FIFO_RD_LEVEL_EN adds the rlevel occupancy output.
module fifo_rd_ctrl
    import fifo_pkg::*;
#(
    parameter int DATASIZE = 8,
    parameter int ADDRSIZE = 4
) (
    input  logic                 rclk,
    input  logic                 rrst,
    input  logic [ADDRSIZE:0]    wptr,
    output logic [ADDRSIZE:0]    rptr,
    output logic [ADDRSIZE-1:0]  raddr,
    input  logic [DATASIZE-1:0]  mem_rdata,
    output logic                 rempty,
    output logic                 out_valid,
    input  logic                 out_ready,
`ifdef FIFO_RD_LEVEL_EN
    output logic [DATASIZE-1:0]  out_data,
    output logic [ADDRSIZE:0]    rlevel
`else
    output logic [DATASIZE-1:0]  out_data
`endif
);

    localparam int PW = ADDRSIZE + 1;

    logic [ADDRSIZE:0] rq2_wptr;
    logic [ADDRSIZE:0] rbin;
    logic [ADDRSIZE:0] rbinnext;
    logic [ADDRSIZE:0] rgraynext;
    logic              pop;

    sync_w2r #(
        .ADDRSIZE (ADDRSIZE)
    ) u_sync_w2r (
        .rclk     (rclk),
        .rrst     (rrst),
        .wptr     (wptr),
        .rq2_wptr (rq2_wptr)
    );

    // A word leaves memory whenever the output register is free or being drained this cycle.
    always_comb begin
        pop       = !rempty && (!out_valid || out_ready);
        rbinnext  = rbin + PW'(pop);
        rgraynext = PW'(bin2gray(FIFO_PTR_MAX'(rbinnext)));
    end

    assign raddr = rbin[ADDRSIZE-1:0];

    always_ff @(posedge rclk) begin
        if (rrst) begin
            rbin   <= '0;
            rptr   <= '0;
            rempty <= 1'b1;
        end else begin
            rbin   <= rbinnext;
            rptr   <= rgraynext;
            rempty <= (rgraynext == rq2_wptr);
        end
    end

    always_ff @(posedge rclk) begin
        if (rrst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (pop) begin
            out_valid <= 1'b1;
            out_data  <= mem_rdata;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef FIFO_RD_LEVEL_EN
    // Memory-side occupancy only; the word parked in out_data is not counted.
    assign rlevel = PW'(gray2bin(FIFO_PTR_MAX'(rq2_wptr))) - rbin;
`endif

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Scoreboard bench for fifo_rd_ctrl with a 16-entry memory and behavioural write side.
module tb_fifo_rd_ctrl;

    localparam int DW = 8;
    localparam int AW = 4;

    logic          rclk = 1'b0;
    logic          rrst;
    logic [AW:0]   wptr;
    logic [AW:0]   rptr;
    logic [AW-1:0] raddr;
    logic [DW-1:0] mem_rdata;
    logic          rempty;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
`ifdef FIFO_RD_LEVEL_EN
    logic [AW:0]   rlevel;
`endif

    logic [DW-1:0] mem [16];
    assign mem_rdata = mem[raddr];

    always #5 rclk = ~rclk;

    fifo_rd_ctrl #(
        .DATASIZE (DW),
        .ADDRSIZE (AW)
    ) dut (
        .rclk      (rclk),
        .rrst      (rrst),
        .wptr      (wptr),
        .rptr      (rptr),
        .raddr     (raddr),
        .mem_rdata (mem_rdata),
        .rempty    (rempty),
        .out_valid (out_valid),
        .out_ready (out_ready),
`ifdef FIFO_RD_LEVEL_EN
        .out_data  (out_data),
        .rlevel    (rlevel)
`else
        .out_data  (out_data)
`endif
    );

    int          tests = 0;
    int          fails = 0;
    logic [DW-1:0] exp_q [$];
    int unsigned wbin = 0;
    int unsigned wcnt = 0;
    int unsigned consumed = 0;
    int unsigned pops;
    int unsigned h0 = 0, h1 = 0, h2 = 0;
    bit          prev_rst = 1'b1;
    bit          hold_v = 1'b0;
    logic [DW-1:0] hold_d;

    function automatic logic [AW:0] g5(input int unsigned b);
        logic [AW:0] x;
        x = b[AW:0];
        return x ^ (x >> 1);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge rclk);
        #1;
    endtask

    task automatic write_word(input logic [DW-1:0] d, input bit commit);
        mem[wbin % 16] = d;
        exp_q.push_back(d);
        wbin++;
        if (commit) begin
            wptr = g5(wbin);
            wcnt = wbin;
        end
    endtask

    task automatic do_reset();
        tick();
        rrst = 1'b1;
        wbin = 0;
        wcnt = 0;
        wptr = '0;
        exp_q.delete();
        repeat (3) tick();
        rrst = 1'b0;
    endtask

    task automatic stream(input int unsigned n, input bit rnd);
        int unsigned wr = 0;
        int unsigned cyc = 0;
        while (consumed < n && cyc < 3000) begin
            tick();
            cyc++;
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (wr < n && (wbin - consumed) < 16 && (!rnd || $urandom_range(0, 2) != 0)) begin
                write_word(rnd ? DW'($urandom) : DW'(wr), 1'b1);
                wr++;
            end
        end
        check("stream_count", consumed, n);
        check("stream_queue_empty", exp_q.size(), 0);
    endtask

    // Monitor: pointer/flag model from written and consumed counts, plus data scoreboard.
    always @(negedge rclk) begin
        if (prev_rst) begin
            check("rst_rempty", rempty, 1);
            check("rst_out_valid", out_valid, 0);
            check("rst_rptr", rptr, 0);
            check("rst_out_data", out_data, 0);
        end else begin
            pops = consumed + 32'(out_valid);
            check("rptr_model", rptr, g5(pops));
            check("raddr_model", raddr, pops % 16);
            check("rempty_model", rempty, (h2 % 32) == (pops % 32));
`ifdef FIFO_RD_LEVEL_EN
            check("rlevel_model", rlevel, (h1 - pops) % 32);
`endif
            if (hold_v) begin
                check("hold_valid", out_valid, 1);
                check("hold_data", out_data, hold_d);
            end
            if (out_valid && out_ready && !rrst) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_word", 1, 0);
                end else begin
                    check("out_data_order", out_data, exp_q.pop_front());
                end
                consumed++;
            end
        end
        if (rrst) consumed = 0;
        hold_v   = out_valid && !out_ready && !rrst;
        hold_d   = out_data;
        h2       = h1;
        h1       = h0;
        h0       = wcnt;
        prev_rst = rrst;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rrst      = 1'b1;
        wptr      = '0;
        out_ready = 1'b0;
        for (int i = 0; i < 16; i++) mem[i] = '0;

        // Reset, then idle with wptr=0
        repeat (3) tick();
        rrst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge rclk);
            check("idle_rempty", rempty, 1);
            check("idle_out_valid", out_valid, 0);
            check("idle_rptr", rptr, 0);
            check("idle_raddr", raddr, 0);
        end

        // Single word latency
        do_reset();
        out_ready = 1'b1;
        tick();
        write_word(8'hA5, 1'b1);
        for (int k = 1; k <= 4; k++) begin
            @(posedge rclk);
            @(negedge rclk);
            if (k == 2) check("single_rempty_e2", rempty, 1);
            if (k == 3) begin
                check("single_rempty_e3", rempty, 0);
                check("single_valid_e3", out_valid, 0);
            end
            if (k == 4) begin
                check("single_valid_e4", out_valid, 1);
                check("single_data_e4", out_data, 8'hA5);
                check("single_rptr_e4", rptr, 5'b00001);
                check("single_rempty_e4", rempty, 1);
            end
        end
        repeat (3) tick();

        // Backpressure
        do_reset();
        out_ready = 1'b0;
        tick();
        write_word(8'h11, 1'b0);
        write_word(8'h22, 1'b0);
        write_word(8'h33, 1'b0);
        write_word(8'h44, 1'b1);
        repeat (8) tick();
        @(negedge rclk);
        check("bp_valid", out_valid, 1);
        check("bp_data", out_data, 8'h11);
        check("bp_rptr", rptr, g5(1));
        check("bp_rempty", rempty, 0);
        tick();
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            logic [DW-1:0] bp_exp [4];
            bp_exp = '{8'h11, 8'h22, 8'h33, 8'h44};
            @(negedge rclk);
            check("bp_burst_valid", out_valid, 1);
            check("bp_burst_data", out_data, bp_exp[i]);
        end
        @(negedge rclk);
        check("bp_drained", out_valid, 0);

        // Wrap-around streams
        do_reset();
        stream(40, 1'b0);
        repeat (4) tick();
        @(negedge rclk);
        check("wrap_end_rempty", rempty, 1);
        check("wrap_end_valid", out_valid, 0);
        do_reset();
        stream(70, 1'b1);

        // Reset mid-stream
        do_reset();
        out_ready = 1'b0;
        tick();
        for (int i = 0; i < 6; i++) write_word(DW'(8'h60 + i), i == 5);
        repeat (7) tick();
        @(negedge rclk);
        check("mid_pre_valid", out_valid, 1);
        check("mid_pre_rempty", rempty, 0);
        tick();
        rrst = 1'b1;
        wbin = 0;
        wcnt = 0;
        wptr = '0;
        exp_q.delete();
        @(negedge rclk);
        @(negedge rclk);
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_rempty", rempty, 1);
        check("mid_rst_rptr", rptr, 0);
        tick();
        tick();
        rrst = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge rclk);
            check("mid_quiet_valid", out_valid, 0);
            check("mid_quiet_rempty", rempty, 1);
        end
        stream(3, 1'b0);

`ifdef FIFO_RD_LEVEL_EN
        // Level output
        do_reset();
        out_ready = 1'b0;
        tick();
        for (int i = 0; i < 16; i++) write_word(DW'(8'hC0 + i), i == 15);
        for (int k = 1; k <= 3; k++) begin
            @(posedge rclk);
            @(negedge rclk);
        end
        check("level_full", rlevel, 16);
        tick();
        out_ready = 1'b1;
        for (int c = 0; c < 100 && consumed < 16; c++) tick();
        @(negedge rclk);
        check("level_count", consumed, 16);
        check("level_zero", rlevel, 0);
        check("level_rempty", rempty, 1);
`endif

        repeat (3) tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
